ram_copy_engine: RTL
====================

RAM_COPY_ENGINE -- requirements
Module: ram_copy_engine

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, RAM address width in bits.
REQ-002 SHALL have parameter DATA_W, default 8, RAM data width in bits.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  asynchronous active-high reset.
REQ-006 SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-007 SHALL have port mode  input  1  transfer mode: 0 = copy, 1 = fill.
REQ-008 SHALL have port abort  input  1  cancels the active transfer.
REQ-009 SHALL have port src  input  ADDR_W  copy source base address.
REQ-010 SHALL have port dst  input  ADDR_W  destination base address.
REQ-011 SHALL have port len  input  ADDR_W  byte count; 0 = no-op.
REQ-012 SHALL have port fill_val  input  DATA_W  constant written in fill mode.
REQ-013 SHALL have port busy  output  1  transfer in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port ram_we  output  1  RAM write enable.
REQ-016 SHALL have port ram_addr  output  ADDR_W  RAM address.
REQ-017 SHALL have port ram_wdata  output  DATA_W  RAM write data.
REQ-018 SHALL have port ram_rdata  input  DATA_W  RAM read data.

Function
REQ-019 SHALL register all outputs; no combinational input-to-output path.
REQ-020 SHALL implement FSM states IDLE, RD_ADDR, RD_CAP, WR, DONE.
REQ-021 SHALL, in IDLE with start=1 and len!=0, latch src/dst/len/mode/fill_val and enter RD_ADDR (copy) or WR (fill), asserting busy from the next cycle.
REQ-022 SHALL, in IDLE with start=1 and len==0, go directly to DONE without any RAM access.
REQ-023 SHALL ignore start, and all other inputs except abort, whenever the FSM is not in IDLE; latched values govern the transfer.
REQ-024 SHALL process bytes at index i = 0..len-1 in ascending order.
REQ-025 SHALL, in copy mode, handle each byte as follows:
- RD_ADDR: drive ram_addr=src+i with ram_we=0.
- RD_CAP: hold the same address and capture ram_rdata at the cycle-end edge (one-cycle read latency).
- WR: drive ram_addr=dst+i, ram_wdata=captured byte, ram_we=1.
REQ-026 SHALL, in fill mode, spend one WR cycle per byte with ram_addr=dst+i, ram_wdata=fill_val, ram_we=1.
REQ-027 SHALL compute addresses modulo 2^ADDR_W (0xFF+1 wraps to 0x00).
REQ-028 SHALL, after the WR for byte len-1, enter DONE.
- DONE lasts one cycle: done=1, busy=0, ram_we=0.
- DONE is followed by IDLE.
REQ-029 SHALL take exactly 3*len cycles for a copy and len cycles for a fill, from first busy cycle to DONE.
REQ-030 SHALL make copies non-overlap-safe: when dst lies in (src, src+len), already-overwritten source bytes are re-read as written.
REQ-031 SHALL, on abort=1 in any non-IDLE state, go to IDLE on the next edge.
- ram_we=0 and busy=0 from that edge; done is not pulsed.
- Writes already committed remain.
REQ-032 SHALL give abort priority over completion when both occur in the same cycle.
REQ-033 SHALL hold ram_we=0 in IDLE, RD_ADDR, RD_CAP and DONE.

Reset
REQ-034 SHALL, on rst=1, asynchronously force state=IDLE, busy=0, done=0, ram_we=0, ram_addr=0, ram_wdata=0, and clear all latched registers.
REQ-035 SHALL, on reset mid-transfer, issue no further writes and no done pulse; the transfer is lost.
REQ-036 SHALL, after rst deasserts, accept start on the first subsequent rising edge.

Verification
REQ-037 SHALL verify the copy scenario: RAM preloaded 0x10=0xAB, 0x11=0xCD; copy src=0x10 dst=0x40 len=2 -> 0x40=0xAB, 0x41=0xCD; done high exactly 7 cycles after the start edge; busy high for 6 cycles.
REQ-038 SHALL verify the fill scenario: fill dst=0xFE len=4 fill_val=0x5A -> 0xFE, 0xFF, 0x00, 0x01 each hold 0x5A (wrap); exactly 4 ram_we cycles.
REQ-039 SHALL verify the no-op scenario: len=0 with start -> done pulse on the next cycle; ram_we never asserted; RAM unchanged.
REQ-040 SHALL verify the abort scenario: abort during the 2nd byte of a copy len=4 -> byte 0 written, bytes 1-3 untouched, no done pulse, busy=0 one cycle after abort.
REQ-041 SHALL verify the mid-transfer reset scenario: rst pulsed mid-fill -> outputs zero immediately (asynchronously); a new copy started after reset completes correctly.
REQ-042 SHALL verify that start is ignored while busy: start reasserted with different dst -> original transfer completes unaltered; the second request is not executed.

Source files
------------

// File: rtl/ram_copy_engine.sv
// Byte copy/fill engine driving a single-port synchronous RAM.
// Copy moves len bytes src->dst with a one-cycle read latency; fill writes a constant.
module ram_copy_engine #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src,
  input  logic [ADDR_W-1:0] dst,
  input  logic [ADDR_W-1:0] len,
  input  logic [DATA_W-1:0] fill_val,
  output logic              busy,
  output logic              done,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_CAP, WR, DONE} state_t;

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] src_q, dst_q, len_q, idx, idx_nxt;
  logic              mode_q;
  logic [DATA_W-1:0] fill_q;
  logic              load;
  logic              last;
  logic              busy_nxt, done_nxt, we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  assign last = (idx == len_q - ONE);

  // Outputs are computed for the upcoming state and registered with it,
  // so each output reflects the state it belongs to without a comb path.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    load      = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = ram_addr;
    wdata_nxt = ram_wdata;
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              load     = 1'b1;
              idx_nxt  = '0;
              busy_nxt = 1'b1;
              if (mode) begin
                state_nxt = WR;
                addr_nxt  = dst;
                wdata_nxt = fill_val;
                we_nxt    = 1'b1;
              end else begin
                state_nxt = RD_ADDR;
                addr_nxt  = src;
              end
            end
          end
        end
        RD_ADDR: begin
          state_nxt = RD_CAP;
          busy_nxt  = 1'b1;
        end
        RD_CAP: begin
          // read data is valid this cycle; it becomes the write data
          state_nxt = WR;
          busy_nxt  = 1'b1;
          addr_nxt  = dst_q + idx;
          wdata_nxt = ram_rdata;
          we_nxt    = 1'b1;
        end
        WR: begin
          if (last) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt  = idx + ONE;
            busy_nxt = 1'b1;
            if (mode_q) begin
              state_nxt = WR;
              addr_nxt  = dst_q + idx + ONE;
              wdata_nxt = fill_q;
              we_nxt    = 1'b1;
            end else begin
              state_nxt = RD_ADDR;
              addr_nxt  = src_q + idx + ONE;
            end
          end
        end
        DONE: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      fill_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      ram_we    <= we_nxt;
      ram_addr  <= addr_nxt;
      ram_wdata <= wdata_nxt;
      if (load) begin
        src_q  <= src;
        dst_q  <= dst;
        len_q  <= len;
        mode_q <= mode;
        fill_q <= fill_val;
      end
    end
  end

endmodule
